// File: rtl/itrx_amba3_axi_pkg.sv
// AXI3 read-channel types and the burst address / response classification helpers
// shared by the read slave and its bench.
package itrx_amba3_axi_pkg;

   typedef logic [3:0]  t_xid;
   typedef logic [31:0] t_xaddr;
   typedef logic [3:0]  t_xlen;

   typedef enum logic [2:0] {
      XSIZE_1B, XSIZE_2B, XSIZE_4B, XSIZE_8B,
      XSIZE_16B, XSIZE_32B, XSIZE_64B, XSIZE_128B
   } te_xsize;

   typedef enum logic [1:0] {XBURST_FIXED, XBURST_INCR, XBURST_WRAP, XBURST_RSVD} te_xburst;
   typedef enum logic [1:0] {XLOCK_NORMAL, XLOCK_EXCL, XLOCK_LOCKED, XLOCK_RSVD} te_xlock;

   typedef enum logic [3:0] {
      XCACHE_DEV_NB = 4'h0,
      XCACHE_DEV_B  = 4'h1,
      XCACHE_NC     = 4'h2,
      XCACHE_NC_B   = 4'h3
   } te_xcache;

   typedef struct packed {
      logic instr;
      logic nonsec;
      logic priv;
   } ts_xprot;

   typedef enum logic [1:0] {XRESP_OKAY, XRESP_EXOKAY, XRESP_SLVERR, XRESP_DECERR} te_xresp;

   function automatic t_xaddr f_wrap_mask(input t_xlen len, input te_xsize size);
      t_xaddr w_beats;
      w_beats = t_xaddr'(len) + 32'd1;
      return (w_beats << size) - 32'd1;
   endfunction

   // Address of the beat following addr; INCR/WRAP first align to the beat size.
   function automatic t_xaddr f_next_addr(input t_xaddr addr, input te_xburst burst,
                                          input te_xsize size, input t_xlen len);
      t_xaddr w_step;
      t_xaddr w_inc;
      t_xaddr w_mask;
      t_xaddr w_res;
      w_step = 32'd1 << size;
      w_inc  = (addr & ~(w_step - 32'd1)) + w_step;
      w_mask = f_wrap_mask(len, size);
      case (burst)
         XBURST_FIXED: w_res = addr;
         XBURST_WRAP:  w_res = (addr & ~w_mask) | (w_inc & w_mask);
         default:      w_res = w_inc;
      endcase
      return w_res;
   endfunction

   function automatic te_xresp f_classify(input te_xburst burst, input te_xsize size,
                                          input t_xlen len, input logic addr_oor,
                                          input te_xsize max_size);
      logic w_wrap_len_ok;
      w_wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
      if (addr_oor)
         return XRESP_DECERR;
      else if ((burst == XBURST_RSVD) || (size > max_size) ||
               ((burst == XBURST_WRAP) && !w_wrap_len_ok))
         return XRESP_SLVERR;
      else
         return XRESP_OKAY;
   endfunction

endpackage

// File: rtl/itrx_amba3_axi_rd_fifo.sv
// Two-entry FIFO; data visible at the head the cycle after push.
// Push while full is not guarded: the producer throttles on o_cnt.
module itrx_amba3_axi_rd_fifo #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push_vld,
   input  logic [W-1:0] i_push_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_head_dat,
   output logic [1:0]   o_cnt
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (i_push_vld) begin
            r_mem[r_wptr] <= i_push_dat;
            r_wptr        <= ~r_wptr;
         end
         if (i_pop)
            r_rptr <= ~r_rptr;
         case ({i_push_vld, i_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign o_head_dat = r_mem[r_rptr];
   assign o_cnt      = r_cnt;

endmodule

// File: rtl/itrx_amba3_axi_rd_slv.sv
// AXI3 read slave, one burst at a time: first rvalid 3 cycles after AR handshake.
// rready low stalls memory reads through a 2-entry FIFO credit; arready only in IDLE.
module itrx_amba3_axi_rd_slv
   import itrx_amba3_axi_pkg::*;
#(
   parameter int XDATAW = 64,
   parameter int MEM_AW = 16
) (
   input  logic                                 aclk,
   input  logic                                 areset_n,
   input  t_xid                                 arid,
   input  t_xaddr                               araddr,
   input  t_xlen                                arlen,
   input  te_xsize                              arsize,
   input  te_xburst                             arburst,
   input  te_xlock                              arlock,
   input  te_xcache                             arcache,
   input  ts_xprot                              arprot,
   input  logic                                 arvalid,
   output logic                                 arready,
   output t_xid                                 rid,
   output logic [XDATAW-1:0]                    rdata,
   output te_xresp                              rresp,
   output logic                                 rlast,
   output logic                                 rvalid,
   input  logic                                 rready,
   output logic                                 mem_re,
   output logic [MEM_AW-$clog2(XDATAW/8)-1:0]   mem_addr,
   input  logic [XDATAW-1:0]                    mem_rdata
);

   localparam int      SH        = $clog2(XDATAW/8);
   localparam int      FW        = XDATAW + 3;
   localparam t_xaddr  ADDR_MASK = t_xaddr'((64'd1 << MEM_AW) - 64'd1);
   localparam te_xsize MAX_SIZE  = te_xsize'(SH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} te_state;

   te_state    r_state;
   te_state    w_nstate;
   t_xid       r_id;
   te_xburst   r_burst;
   te_xsize    r_size;
   t_xlen      r_len;
   t_xlen      r_beat;
   t_xaddr     r_addr;
   te_xresp    r_resp;
   logic       r_rd_vld;
   logic       r_rd_last;
   logic       r_alive;

   logic          w_hs;
   logic          w_issue;
   logic          w_last_beat;
   logic          w_err;
   logic          w_pop;
   logic          w_push;
   logic          w_credit_ok;
   logic [1:0]    w_fifo_cnt;
   logic [1:0]    w_occ;
   logic [FW-1:0] w_push_dat;
   logic [FW-1:0] w_head_dat;
   te_xresp       w_ar_resp;
   logic          w_unused;

   assign w_unused    = ^{arlock, arcache, arprot};
   assign w_err       = (r_resp != XRESP_OKAY);
   assign w_last_beat = (r_beat == r_len);
   assign w_pop       = rvalid & rready;
   // Occupancy after this cycle's pop, counting the read whose data lands next cycle.
   assign w_occ       = w_fifo_cnt + {1'b0, r_rd_vld} - {1'b0, w_pop};
   assign w_credit_ok = (w_occ < 2'd2);
   assign w_ar_resp   = f_classify(arburst, arsize, arlen, |(araddr & ~ADDR_MASK), MAX_SIZE);

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n)
         r_state <= S_IDLE;
      else
         r_state <= w_nstate;
   end

   always_comb begin
      w_nstate = r_state;
      arready  = 1'b0;
      w_issue  = 1'b0;
      case (r_state)
         S_IDLE: begin
            arready = r_alive;
            if (arvalid && r_alive)
               w_nstate = S_ISSUE;
         end
         S_ISSUE: begin
            w_issue = w_credit_ok;
            if (w_credit_ok && w_last_beat)
               w_nstate = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_pop && rlast)
               w_nstate = S_IDLE;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   assign w_hs   = arvalid & arready;
   assign mem_re = w_issue & ~w_err;

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         r_alive   <= 1'b0;
         r_id      <= '0;
         r_burst   <= XBURST_FIXED;
         r_size    <= XSIZE_1B;
         r_len     <= '0;
         r_beat    <= '0;
         r_addr    <= '0;
         r_resp    <= XRESP_OKAY;
         r_rd_vld  <= 1'b0;
         r_rd_last <= 1'b0;
      end else begin
         r_alive   <= 1'b1;
         r_rd_vld  <= mem_re;
         r_rd_last <= w_last_beat;
         if (w_hs) begin
            r_id    <= arid;
            r_burst <= arburst;
            r_size  <= arsize;
            r_len   <= arlen;
            r_addr  <= araddr & ADDR_MASK;
            r_resp  <= w_ar_resp;
            r_beat  <= '0;
         end else if (w_issue) begin
            r_beat <= r_beat + 4'd1;
            r_addr <= f_next_addr(r_addr, r_burst, r_size, r_len) & ADDR_MASK;
         end
      end
   end

   // Error bursts skip memory and push zero-data beats straight into the FIFO.
   assign w_push     = r_rd_vld | (w_issue & w_err);
   assign w_push_dat = r_rd_vld ? {mem_rdata, XRESP_OKAY, r_rd_last}
                                : {{XDATAW{1'b0}}, r_resp, w_last_beat};

   itrx_amba3_axi_rd_fifo #(.W(FW)) u_fifo (
      .i_clk      (aclk),
      .i_rst_n    (areset_n),
      .i_push_vld (w_push),
      .i_push_dat (w_push_dat),
      .i_pop      (w_pop),
      .o_head_dat (w_head_dat),
      .o_cnt      (w_fifo_cnt)
   );

   assign rvalid   = (w_fifo_cnt != 2'd0);
   assign rdata    = w_head_dat[FW-1:3];
   assign rresp    = te_xresp'(w_head_dat[2:1]);
   assign rlast    = rvalid & w_head_dat[0];
   assign rid      = r_id;
   assign mem_addr = r_addr[MEM_AW-1:SH];

endmodule

// File: tb/tb_itrx_amba3_axi_rd_slv.sv
// Directed plus randomized bursts for the AXI3 read slave, checked beat by beat
// against per-beat addresses and responses computed from the burst rules.
module tb_itrx_amba3_axi_rd_slv;
   import itrx_amba3_axi_pkg::*;

   logic        aclk = 1'b0;
   logic        areset_n;
   t_xid        arid;
   t_xaddr      araddr;
   t_xlen       arlen;
   te_xsize     arsize;
   te_xburst    arburst;
   te_xlock     arlock;
   te_xcache    arcache;
   ts_xprot     arprot;
   logic        arvalid;
   logic        arready;
   t_xid        rid;
   logic [63:0] rdata;
   te_xresp     rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic        mem_re;
   logic [12:0] mem_addr;
   logic [63:0] mem_rdata;

   itrx_amba3_axi_rd_slv #(.XDATAW(64), .MEM_AW(16)) dut (
      .aclk      (aclk),
      .areset_n  (areset_n),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arlock    (arlock),
      .arcache   (arcache),
      .arprot    (arprot),
      .arvalid   (arvalid),
      .arready   (arready),
      .rid       (rid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata)
   );

   always #5 aclk = ~aclk;

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int g_T, g_first_re, g_first_rv, g_last;
   t_xid        nx_id;
   t_xaddr      nx_addr;
   logic [3:0]  nx_len;
   logic [2:0]  nx_size;
   logic [1:0]  nx_burst;
   logic [3:0]  wrap_lens [4] = '{4'd1, 4'd3, 4'd7, 4'd15};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] data_of(input logic [12:0] w);
      return {16'hC0DE, 3'b000, w, 32'(w) * 32'h9E37_79B9};
   endfunction

   // 0 OKAY, 2 SLVERR, 3 DECERR
   function automatic logic [1:0] exp_resp(input t_xaddr a, input logic [3:0] l,
                                           input logic [2:0] s, input logic [1:0] b);
      if ((a >> 16) != 0) return 2'd3;
      if (b == 2'd3) return 2'd2;
      if (s > 3'd3) return 2'd2;
      if (b == 2'd2 && !(l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15)) return 2'd2;
      return 2'd0;
   endfunction

   function automatic t_xaddr exp_addr(input t_xaddr a, input logic [3:0] l, input logic [2:0] s,
                                       input logic [1:0] b, input int n);
      int unsigned bytes, total, start, aligned, base;
      start   = a;
      bytes   = 32'd1 << s;
      aligned = start - (start % bytes);
      if (n == 0 || b == 2'd0) return a;
      if (b == 2'd2) begin
         total = (int'(l) + 1) * bytes;
         base  = start - (start % total);
         return base + ((aligned - base) + n * bytes) % total;
      end
      return (aligned + n * bytes) % 65536;
   endfunction

   task automatic do_reset();
      areset_n = 1'b0;
      #1;
      chk("rst_arready", arready, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rlast", rlast, 0);
      chk("rst_rid", rid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_rresp", rresp, XRESP_OKAY);
      chk("rst_mem_re", mem_re, 0);
      chk("rst_mem_addr", mem_addr, 0);
      arvalid = 1'b0;
      rready  = 1'b0;
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      @(negedge aclk);
      #1;
      chk("rst_arready_rise", arready, 1);
   endtask

   // rmode: 0 rready high, 1 toggling from high, 2 random. abort_at: reset once that many beats popped.
   task automatic run_burst(input t_xid id, input t_xaddr a, input logic [3:0] l, input logic [2:0] s,
                            input logic [1:0] b, input int rmode, input int abort_at, input bit hold_next);
      t_xaddr      ea [16];
      logic [63:0] ed [16];
      logic [1:0]  er;
      int          nb, n_re, n_pop, tmo;
      bit          stall, done, pend, seen_rv, rr;
      logic [12:0] paddr;
      logic [63:0] p_dat;
      logic [1:0]  p_resp;
      logic        p_last;
      t_xid        p_id;
      er = exp_resp(a, l, s, b);
      nb = int'(l) + 1;
      for (int n = 0; n < nb; n++) begin
         ea[n] = exp_addr(a, l, s, b, n);
         ed[n] = (er == 2'd0) ? data_of(13'(ea[n] >> 3)) : 64'd0;
      end
      n_re = 0; n_pop = 0; tmo = 0;
      stall = 0; done = 0; pend = 0; seen_rv = 0; rr = 0;
      paddr = '0; p_dat = '0; p_resp = '0; p_last = 0; p_id = '0;
      do begin
         @(negedge aclk);
         arid = id; araddr = a; arlen = l; arsize = te_xsize'(s); arburst = te_xburst'(b);
         arvalid = 1'b1;
         #1;
         tmo++;
      end while (!arready && tmo < 50);
      chk("ar_accept", arready, 1);
      g_T = cyc;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge aclk);
         if (k == 0) begin
            if (hold_next) begin
               arid = nx_id; araddr = nx_addr; arlen = nx_len;
               arsize = te_xsize'(nx_size); arburst = te_xburst'(nx_burst);
            end else
               arvalid = 1'b0;
         end
         mem_rdata = pend ? data_of(paddr) : {$urandom, $urandom};
         rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~rr : 1'($urandom_range(0, 1));
         rready = rr;
         #1;
         if (abort_at >= 0 && n_pop == abort_at) begin
            do_reset();
            return;
         end
         if (hold_next) chk("ar_pending_low", arready, 0);
         pend  = mem_re;
         paddr = mem_addr;
         if (mem_re) begin
            if (n_re == 0) g_first_re = cyc;
            chk("mem_addr", mem_addr, 13'(ea[n_re % 16] >> 3));
            n_re++;
         end
         if (stall) begin
            chk("hold_rvalid", rvalid, 1);
            chk("hold_rdata", rdata, p_dat);
            chk("hold_rresp", rresp, p_resp);
            chk("hold_rlast", rlast, p_last);
            chk("hold_rid", rid, p_id);
         end
         if (rvalid && !seen_rv) begin
            seen_rv    = 1;
            g_first_rv = cyc;
         end
         if (rvalid && rready) begin
            chk("rid", rid, id);
            chk("rdata", rdata, ed[n_pop % 16]);
            chk("rresp", rresp, er);
            chk("rlast", rlast, (n_pop == nb - 1));
            n_pop++;
            if (rlast) begin
               done   = 1;
               g_last = cyc;
            end
         end
         if (mem_re) chk("outstanding_le2", ((n_re - n_pop) <= 2), 1);
         stall  = rvalid && !rready;
         p_dat  = rdata;
         p_resp = rresp;
         p_last = rlast;
         p_id   = rid;
      end
      chk("burst_done", done, 1);
      chk("beat_count", n_pop, nb);
      chk("mem_re_count", n_re, (er == 2'd0) ? nb : 0);
   endtask

   initial begin
      int l_first;
      logic [3:0] l;
      logic [2:0] s;
      logic [1:0] b;
      t_xaddr     a;
      areset_n  = 1'b0;
      arvalid   = 1'b0;
      arid      = '0;
      araddr    = '0;
      arlen     = '0;
      arsize    = XSIZE_1B;
      arburst   = XBURST_FIXED;
      arlock    = XLOCK_NORMAL;
      arcache   = XCACHE_DEV_NB;
      arprot    = '0;
      rready    = 1'b0;
      mem_rdata = '0;
      @(negedge aclk);
      do_reset();

      run_burst(4'h3, 32'h0000_0100, 4'd3, 3'd3, 2'd1, 0, -1, 1'b0);
      chk("lat_mem_re", g_first_re, g_T + 1);
      chk("lat_rvalid", g_first_rv, g_T + 3);
      chk("lat_rlast", g_last, g_T + 6);

      run_burst(4'h1, 32'h0000_0118, 4'd3, 3'd3, 2'd2, 0, -1, 1'b0);
      run_burst(4'h2, 32'h0000_0040, 4'd7, 3'd3, 2'd1, 1, -1, 1'b0);
      run_burst(4'h4, 32'h0000_0200, 4'd2, 3'd3, 2'd3, 0, -1, 1'b0);
      run_burst(4'h6, 32'h0001_0000, 4'd1, 3'd3, 2'd1, 2, -1, 1'b0);
      run_burst(4'h7, 32'h0000_0300, 4'd2, 3'd3, 2'd2, 1, -1, 1'b0);
      run_burst(4'h8, 32'h0000_0300, 4'd0, 3'd4, 2'd1, 0, -1, 1'b0);
      run_burst(4'hA, 32'h0000_FFF8, 4'd2, 3'd3, 2'd1, 0, -1, 1'b0);

      run_burst(4'h9, 32'h0000_0400, 4'd7, 3'd3, 2'd1, 0, 1, 1'b0);
      run_burst(4'h5, 32'h0000_0480, 4'd7, 3'd3, 2'd1, 0, -1, 1'b0);

      nx_id = 4'hC; nx_addr = 32'h0000_0800; nx_len = 4'd3; nx_size = 3'd2; nx_burst = 2'd1;
      run_burst(4'hB, 32'h0000_0600, 4'd3, 3'd3, 2'd1, 1, -1, 1'b1);
      l_first = g_last;
      run_burst(nx_id, nx_addr, nx_len, nx_size, nx_burst, 0, -1, 1'b0);
      chk("pending_ar_accept", g_T, l_first + 1);

      for (int i = 0; i < 30; i++) begin
         b = 2'($urandom_range(0, 2));
         s = 3'($urandom_range(0, 3));
         l = 4'($urandom_range(0, 15));
         a = t_xaddr'($urandom_range(0, 65535));
         if (b == 2'd2) begin
            l = wrap_lens[$urandom_range(0, 3)];
            a = a & ~((32'd1 << s) - 32'd1);
         end
         if (i % 5 == 4) begin
            case ($urandom_range(0, 3))
               0: b = 2'd3;
               1: s = 3'($urandom_range(4, 7));
               2: begin b = 2'd2; l = 4'($urandom_range(0, 7) * 2); end
               default: a = a | (t_xaddr'($urandom_range(1, 65535)) << 16);
            endcase
         end
         run_burst(4'($urandom_range(0, 15)), a, l, s, b, $urandom_range(0, 2), -1, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/itrx_amba3_axi_rd_slv.md
ITRX_AMBA3_AXI_RD_SLV -- requirements
Module: itrx_amba3_axi_rd_slv

Interface
REQ-001 Parameter XDATAW, default 64, read data width in bits (64 or 32 only).
REQ-002 Parameter MEM_AW, default 16, byte-address bits decoded by the slave.
REQ-003 aclk  in  1  sole clock; all logic rising-edge.
REQ-004 areset_n  in  1  asynchronous, active-low reset.
REQ-005 arid  in  t_xid  read burst ID.
REQ-006 araddr  in  t_xaddr (32)  start byte address.
REQ-007 arlen  in  t_xlen (4)  beats minus one.
REQ-008 arsize  in  te_xsize (3)  log2 bytes per beat.
REQ-009 arburst  in  te_xburst (2)  FIXED/INCR/WRAP/reserved.
REQ-010 arlock, arcache, arprot  in  te_xlock, te_xcache, ts_xprot  accepted, ignored.
REQ-011 arvalid  in  1; arready  out  1  AR handshake.
REQ-012 rid  out  t_xid; rdata  out  XDATAW; rresp  out  te_xresp; rlast  out  1; rvalid  out  1; rready  in  1  R channel.
REQ-013 mem_re  out  1; mem_addr  out  MEM_AW-log2(XDATAW/8)  word address; mem_rdata  in  XDATAW, valid exactly one cycle after mem_re.

Function
REQ-014 One burst outstanding; arready SHALL be high only in IDLE.
REQ-015 FSM: IDLE -(arvalid&&arready)-> ISSUE -(last beat issued/queued)-> DRAIN -(rvalid&&rready&&rlast)-> IDLE.
REQ-016 Burst fields and arid SHALL be captured at AR handshake; rid SHALL equal captured arid for every beat.
REQ-017 Beat count SHALL be arlen+1 (1..16); rlast high on final beat only.
REQ-018 FIXED: every beat uses araddr; INCR: beat n+1 = align(beat n, 2^arsize)+2^arsize; WRAP: same increment, wrapped within aligned block of (arlen+1)<<arsize bytes.
REQ-019 INCR SHALL wrap modulo 2^MEM_AW; no 4 KB check.
REQ-020 mem_addr SHALL be beat byte address >> log2(XDATAW/8).
REQ-021 Beats from memory SHALL pass through a 2-entry FIFO {rdata,rresp,rlast}; mem_re SHALL assert only when FIFO occupancy plus in-flight reads < 2, counting a same-cycle pop.
REQ-022 Latency: AR handshake in cycle T -> mem_re in T+1 -> first rvalid in T+3; with rready held high, one beat per cycle thereafter.
REQ-023 rvalid, once high, SHALL hold with rid/rdata/rresp/rlast stable until rready.
REQ-024 SLVERR bursts: arburst=2'b11, arsize>log2(XDATAW/8), or WRAP with arlen not in {1,3,7,15}; DECERR bursts: araddr[31:MEM_AW]!=0.
REQ-025 Error bursts SHALL issue no mem_re, return arlen+1 beats with rdata=0 and the error rresp, same rlast/throughput rules.
REQ-026 rresp SHALL be OKAY otherwise; EXOKAY never returned.
REQ-027 arvalid while not IDLE SHALL be left pending (arready low), not dropped.

Reset
REQ-028 On areset_n low, immediately: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=OKAY, mem_re=0, mem_addr=0, FIFO empty, FSM IDLE.
REQ-029 Reset mid-burst SHALL abandon the burst; in-flight mem_rdata discarded.
REQ-030 arready SHALL rise in the first cycle after areset_n deasserts.

Structure
REQ-031 Burst next-address and wrap-mask functions and the error-classification function SHALL live in itrx_amba3_axi_pkg beside t_xid/te_xburst/te_xresp.
REQ-032 The 2-entry FIFO SHALL be sub-module itrx_amba3_axi_rd_fifo (parameterized width, count output).
REQ-033 Top level: FSM, beat counter, address generator, credit counter only.

Verification
REQ-034 INCR araddr=0x100, arlen=3, arsize=3, rready=1 -> mem_addr 0x20,0x21,0x22,0x23; rvalid T+3..T+6; rlast on 4th; rresp OKAY.
REQ-035 WRAP araddr=0x118, arlen=3, arsize=3 -> byte addrs 0x118,0x100,0x108,0x110.
REQ-036 INCR arlen=7, rready toggling 1/0 each cycle -> 8 beats in order, no beat lost/duplicated, never >2 reads outstanding.
REQ-037 arburst=2'b11, arlen=2 -> 3 beats SLVERR, rdata 0, zero mem_re; araddr=0x0001_0000 -> DECERR beats.
REQ-038 areset_n low during beat 2 of 8 -> all outputs to REQ-028 values same cycle; next burst arid=5 returns rid=5 clean data.
REQ-039 Second arvalid held during first burst -> accepted cycle after first rlast handshake.
